// File: rtl/fp_busreq_if.sv
// rtl/fp_busreq_if.sv - FPU request and memory bus signal bundle for fp_busreq
interface fp_busreq_if;
  logic        sr_fp;
  logic        read_fp;
  logic [15:0] ad_fp;
  logic [15:0] dt_fp;
  logic        zw;
  logic        ok;
  logic        en;
  logic [15:0] dt_bus;
  logic        zg;
  logic        r;
  logic        w;
  logic [15:0] ad_bus;
  logic [15:0] dt_out;
  logic [15:0] rdata;
  logic        ok_fp;
  logic        nomem;
  logic        alarm;
  logic        busy;

  modport master (
    input  sr_fp, read_fp, ad_fp, dt_fp, zw, ok, en, dt_bus,
    output zg, r, w, ad_bus, dt_out, rdata, ok_fp, nomem, alarm, busy
  );

  modport slave (
    output sr_fp, read_fp, ad_fp, dt_fp, zw, ok, en, dt_bus,
    input  zg, r, w, ad_bus, dt_out, rdata, ok_fp, nomem, alarm, busy
  );
endinterface

// File: rtl/fp_busreq.sv
// rtl/fp_busreq.sv - FPU memory requester: request edge -> granted bus cycle -> completion strobe
module fp_busreq #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic         clk_sys,
  input  logic         reset_,
  fp_busreq_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CMD, S_REL, S_ALM} state_t;

  state_t      state_q, state_n;
  logic        sr_s, sr_q, rfp_s, zw_s, ok_s, en_s;
  logic [15:0] adf_s, dtf_s, dtb_s;
  logic        pend_q, pend_n, rd_q, rd_n;
  logic [7:0]  cnt_q, cnt_n;
  logic        zg_q, zg_n, r_q, r_n, w_q, w_n;
  logic        ok_fp_q, ok_fp_n, nomem_q, nomem_n, alarm_q, alarm_n, busy_q;
  logic [15:0] ad_q, ad_n, dto_q, dto_n, rdata_q, rdata_n;
  logic        req_edge;

  // Every input passes through one register stage, so outputs never see inputs combinationally.
  assign req_edge = sr_s & ~sr_q;

  always_comb begin
    state_n = state_q;
    pend_n  = pend_q;
    rd_n    = rd_q;
    cnt_n   = cnt_q;
    zg_n    = zg_q;
    r_n     = r_q;
    w_n     = w_q;
    ad_n    = ad_q;
    dto_n   = dto_q;
    rdata_n = rdata_q;
    ok_fp_n = 1'b0;
    nomem_n = nomem_q;
    alarm_n = alarm_q;
    if (req_edge && state_q != S_IDLE) pend_n = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req_edge || pend_q) begin
          state_n = S_REQ;
          pend_n  = 1'b0;
          rd_n    = rfp_s;
          ad_n    = adf_s;
          dto_n   = dtf_s;
          nomem_n = 1'b0;
          alarm_n = 1'b0;
          zg_n    = 1'b1;
        end
      end
      S_REQ: begin
        if (zw_s) begin
          state_n = S_CMD;
          r_n     = rd_q;
          w_n     = ~rd_q;
          cnt_n   = 8'd0;
        end
      end
      S_CMD: begin
        if (en_s || ok_s) begin
          state_n = S_REL;
          zg_n    = 1'b0;
          r_n     = 1'b0;
          w_n     = 1'b0;
          ok_fp_n = 1'b1;
          if (en_s)      nomem_n = 1'b1;
          else if (rd_q) rdata_n = dtb_s;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          state_n = S_ALM;
          zg_n    = 1'b0;
          r_n     = 1'b0;
          w_n     = 1'b0;
          ok_fp_n = 1'b1;
          alarm_n = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      S_REL: begin
        if (!ok_s && !en_s) state_n = S_IDLE;
      end
      S_ALM: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_) begin
    if (!reset_) begin
      sr_s    <= 1'b0;
      sr_q    <= 1'b0;
      rfp_s   <= 1'b0;
      zw_s    <= 1'b0;
      ok_s    <= 1'b0;
      en_s    <= 1'b0;
      adf_s   <= 16'd0;
      dtf_s   <= 16'd0;
      dtb_s   <= 16'd0;
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= 8'd0;
      zg_q    <= 1'b0;
      r_q     <= 1'b0;
      w_q     <= 1'b0;
      ad_q    <= 16'd0;
      dto_q   <= 16'd0;
      rdata_q <= 16'd0;
      ok_fp_q <= 1'b0;
      nomem_q <= 1'b0;
      alarm_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sr_s    <= bus.sr_fp;
      sr_q    <= sr_s;
      rfp_s   <= bus.read_fp;
      zw_s    <= bus.zw;
      ok_s    <= bus.ok;
      en_s    <= bus.en;
      adf_s   <= bus.ad_fp;
      dtf_s   <= bus.dt_fp;
      dtb_s   <= bus.dt_bus;
      state_q <= state_n;
      pend_q  <= pend_n;
      rd_q    <= rd_n;
      cnt_q   <= cnt_n;
      zg_q    <= zg_n;
      r_q     <= r_n;
      w_q     <= w_n;
      ad_q    <= ad_n;
      dto_q   <= dto_n;
      rdata_q <= rdata_n;
      ok_fp_q <= ok_fp_n;
      nomem_q <= nomem_n;
      alarm_q <= alarm_n;
      busy_q  <= (state_n != S_IDLE);
    end
  end

  assign bus.zg     = zg_q;
  assign bus.r      = r_q;
  assign bus.w      = w_q;
  assign bus.ad_bus = ad_q;
  assign bus.dt_out = dto_q;
  assign bus.rdata  = rdata_q;
  assign bus.ok_fp  = ok_fp_q;
  assign bus.nomem  = nomem_q;
  assign bus.alarm  = alarm_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_fp_busreq.sv
// tb/tb_fp_busreq.sv - self-checking bench for fp_busreq with arbiter/memory models
module tb_fp_busreq;

  localparam int T = 10;

  logic clk_sys = 1'b0;
  logic reset_  = 1'b1;
  fp_busreq_if bus();

  fp_busreq #(.TIMEOUT(8'd10)) dut (.clk_sys(clk_sys), .reset_(reset_), .bus(bus));

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_fail = 0;

  // environment knobs (written by the stimulus thread only)
  int gnt_dly = 1, rsp_kind = 3, rsp_dly = 0, rsp_hold = 0;
  logic [15:0] bus_word = 16'h0000;

  // arbiter: grant gnt_dly cycles after request seen
  int gcnt = 0;
  always @(negedge clk_sys) begin
    if (!bus.zg) begin
      bus.zw = 1'b0;
      gcnt = 0;
    end else if (gcnt >= gnt_dly) bus.zw = 1'b1;
    else gcnt++;
  end

  // memory: kind 0=ok 1=en 2=both 3=silent; response held rsp_hold cycles past command drop
  int mcnt = 0, hcnt = 0;
  always @(negedge clk_sys) begin
    if (bus.r || bus.w) begin
      hcnt = 0;
      if (mcnt >= rsp_dly && rsp_kind != 3) begin
        bus.ok = (rsp_kind == 0 || rsp_kind == 2);
        bus.en = (rsp_kind == 1 || rsp_kind == 2);
        bus.dt_bus = bus_word;
      end else mcnt++;
    end else begin
      mcnt = 0;
      if ((bus.ok || bus.en) && hcnt < rsp_hold) hcnt++;
      else begin
        bus.ok = 1'b0;
        bus.en = 1'b0;
        bus.dt_bus = ~bus_word;
      end
    end
  end

  // monotonic observation counters
  int cyc = 0, okfp_cnt = 0, r_cnt = 0, w_cnt = 0, rel_cnt = 0, cmd_rise = 0, alarm_rise = 0;
  logic cmd_prev = 1'b0, alarm_prev = 1'b0;
  always @(negedge clk_sys) begin
    cyc++;
    if (bus.ok_fp) okfp_cnt++;
    if (bus.r) r_cnt++;
    if (bus.w) w_cnt++;
    if (bus.busy && !bus.zg && !bus.r && !bus.w) rel_cnt++;
    if ((bus.r || bus.w) && !cmd_prev) cmd_rise = cyc;
    if (bus.alarm && !alarm_prev) alarm_rise = cyc;
    cmd_prev = bus.r || bus.w;
    alarm_prev = bus.alarm;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit rd; logic [15:0] ad, dt, bw;
    int gd, kind, d, h; bit hold;
    bit e_nomem, e_alarm; logic [15:0] e_rdata; int e_rel;
  } vec_t;

  vec_t tbl [8];
  logic [15:0] m_rdata;

  // Spec-level outcome: response is acted on d+2 CMD cycles after command start; timeout fires at CMD cycle T.
  task automatic model(input bit rd, input int kind, input int d, input int h, input logic [15:0] bw,
                       output bit e_nomem, output bit e_alarm, output int e_rel);
    bit timeout;
    timeout = (kind == 3) || (d + 2 > T);
    e_alarm = timeout;
    e_nomem = !timeout && (kind == 1 || kind == 2);
    e_rel   = timeout ? 1 : 2 + h;
    if (!timeout && kind == 0 && rd) m_rdata = bw;
  endtask

  task automatic do_access(input string tag, input vec_t v);
    int ok0, r0, w0, rel0;
    bit saw, done;
    gnt_dly = v.gd; rsp_kind = v.kind; rsp_dly = v.d; rsp_hold = v.h; bus_word = v.bw;
    ok0 = okfp_cnt; r0 = r_cnt; w0 = w_cnt; rel0 = rel_cnt;
    @(negedge clk_sys);
    bus.read_fp = v.rd; bus.ad_fp = v.ad; bus.dt_fp = v.dt; bus.sr_fp = 1'b1;
    saw = 0; done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (bus.busy) begin
        saw = 1;
        if (!v.hold) bus.sr_fp = 1'b0;
      end else if (saw) begin
        done = 1;
        break;
      end
    end
    chk({tag, ".completed"}, int'(done), 1);
    repeat (3) @(negedge clk_sys);
    chk({tag, ".busy_idle"}, int'(bus.busy), 0);
    chk({tag, ".ok_fp_pulses"}, okfp_cnt - ok0, 1);
    chk({tag, ".ad_bus"}, int'(bus.ad_bus), int'(v.ad));
    chk({tag, ".dt_out"}, int'(bus.dt_out), int'(v.dt));
    chk({tag, ".rdata"}, int'(bus.rdata), int'(v.e_rdata));
    chk({tag, ".nomem"}, int'(bus.nomem), int'(v.e_nomem));
    chk({tag, ".alarm"}, int'(bus.alarm), int'(v.e_alarm));
    chk({tag, ".r_seen"}, int'(r_cnt > r0), int'(v.rd));
    chk({tag, ".w_seen"}, int'(w_cnt > w0), int'(!v.rd));
    chk({tag, ".rel_cycles"}, rel_cnt - rel0, v.e_rel);
    if (v.e_alarm) chk({tag, ".alarm_latency"}, alarm_rise - cmd_rise, T);
    bus.sr_fp = 1'b0;
  endtask

  bit lat_zg [7] = '{0, 1, 1, 1, 1, 0, 0};
  bit lat_r  [7] = '{0, 0, 0, 1, 1, 0, 0};
  bit lat_ok [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int base, gap;
    bit seen, fell;

    bus.sr_fp = 0; bus.read_fp = 0; bus.ad_fp = 0; bus.dt_fp = 0;
    #1 reset_ = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("reset.cmds", int'({bus.zg, bus.r, bus.w, bus.ok_fp, bus.busy}), 0);
    chk("reset.flags", int'({bus.nomem, bus.alarm}), 0);
    chk("reset.ad_bus", int'(bus.ad_bus), 0);
    chk("reset.dt_out", int'(bus.dt_out), 0);
    chk("reset.rdata", int'(bus.rdata), 0);
    reset_ = 1'b1;
    repeat (2) @(negedge clk_sys);

    tbl[0] = '{1'b1, 16'h1234, 16'h0000, 16'hBEEF, 1, 0, 3, 0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 2};
    tbl[1] = '{1'b0, 16'h0010, 16'h00FF, 16'h1111, 1, 0, 2, 0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 2};
    tbl[2] = '{1'b1, 16'h2000, 16'h0000, 16'hDEAD, 0, 2, 1, 3, 1'b0, 1'b1, 1'b0, 16'hBEEF, 5};
    tbl[3] = '{1'b0, 16'h3000, 16'h5555, 16'h0000, 2, 1, 0, 0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 2};
    tbl[4] = '{1'b1, 16'h4000, 16'h0000, 16'hCAFE, 1, 3, 0, 0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1};
    tbl[5] = '{1'b1, 16'h5000, 16'h0000, 16'h1357, 3, 0, 8, 1, 1'b0, 1'b0, 1'b0, 16'h1357, 3};
    tbl[6] = '{1'b1, 16'h6000, 16'h0000, 16'h2468, 1, 0, 9, 0, 1'b0, 1'b0, 1'b1, 16'h1357, 1};
    tbl[7] = '{1'b1, 16'h7000, 16'h0000, 16'h0A0A, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0, 16'h0A0A, 4};
    for (int i = 0; i < 8; i++) do_access($sformatf("vec%0d", i), tbl[i]);

    // cycle-exact start / grant / response latency
    gnt_dly = 0; rsp_kind = 0; rsp_dly = 0; rsp_hold = 0; bus_word = 16'h5A5A;
    @(negedge clk_sys);
    bus.read_fp = 1'b1; bus.ad_fp = 16'h0042; bus.sr_fp = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_sys);
      chk($sformatf("lat.zg@%0d", k), int'(bus.zg), int'(lat_zg[k]));
      chk($sformatf("lat.r@%0d", k), int'(bus.r), int'(lat_r[k]));
      chk($sformatf("lat.ok_fp@%0d", k), int'(bus.ok_fp), int'(lat_ok[k]));
    end
    bus.sr_fp = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("lat.busy_idle", int'(bus.busy), 0);
    chk("lat.rdata", int'(bus.rdata), 16'h5A5A);

    // request re-edge during CMD queues a second access one IDLE cycle later
    gnt_dly = 1; rsp_kind = 0; rsp_dly = 3; rsp_hold = 0; bus_word = 16'h7777;
    base = okfp_cnt;
    @(negedge clk_sys);
    bus.read_fp = 1'b1; bus.ad_fp = 16'h0100; bus.sr_fp = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_sys);
      seen = bus.r;
    end
    chk("pend.r_seen", int'(seen), 1);
    bus.sr_fp = 1'b0;
    @(negedge clk_sys);
    bus.sr_fp = 1'b1;
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (!bus.busy) gap++;
      else if (gap > 0) break;
    end
    chk("pend.idle_gap", gap, 1);
    fell = 0;
    for (int i = 0; i < 100 && !fell; i++) begin
      @(negedge clk_sys);
      fell = !bus.busy;
    end
    chk("pend.second_done", int'(fell), 1);
    repeat (3) @(negedge clk_sys);
    chk("pend.ok_fp_pulses", okfp_cnt - base, 2);
    bus.sr_fp = 1'b0;
    m_rdata = 16'h7777;

    // randomized accesses against the outcome model
    for (int i = 0; i < 40; i++) begin
      v.rd = 1'($urandom_range(0, 1));
      v.ad = 16'($urandom); v.dt = 16'($urandom); v.bw = 16'($urandom);
      v.gd = $urandom_range(0, 3); v.kind = $urandom_range(0, 3);
      v.d = $urandom_range(0, 11); v.h = $urandom_range(0, 2);
      v.hold = 1'($urandom_range(0, 1));
      model(v.rd, v.kind, v.d, v.h, v.bw, v.e_nomem, v.e_alarm, v.e_rel);
      v.e_rdata = m_rdata;
      do_access($sformatf("rnd%0d", i), v);
    end

    // asynchronous reset in the middle of a command
    gnt_dly = 1; rsp_kind = 3; rsp_dly = 0; rsp_hold = 0;
    @(negedge clk_sys);
    bus.read_fp = 1'b0; bus.ad_fp = 16'hABCD; bus.dt_fp = 16'h0001; bus.sr_fp = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_sys);
      seen = bus.w;
    end
    chk("rst.w_seen", int'(seen), 1);
    repeat (2) @(negedge clk_sys);
    base = okfp_cnt;
    #2 reset_ = 1'b0;
    #1;
    chk("rst.async_cmds", int'({bus.zg, bus.r, bus.w, bus.busy}), 0);
    chk("rst.ad_bus", int'(bus.ad_bus), 0);
    chk("rst.rdata", int'(bus.rdata), 0);
    bus.sr_fp = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_ = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst.no_ok_fp", okfp_cnt - base, 0);
    v = '{1'b1, 16'h0BAD, 16'h0000, 16'h600D, 1, 0, 2, 0, 1'b0, 1'b0, 1'b0, 16'h600D, 2};
    do_access("rst.fresh", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
